// File: rtl/wb_load_unit.sv
// wb_load_unit
//
// Writeback stage between mem_wb_reg and the register file.
// Non-load results, and loads whose Dcache data arrives in the same cycle,
// are written back combinationally. A load whose data is late stalls the
// pipeline in WAIT until the data pulse arrives or a bounded timeout expires.
// A timed-out load is dropped and flagged with a one-cycle error pulse.
// Every completion, including dropped loads, bumps the retire counter.
//
// State table:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no load outstanding; upstream fields drive the outputs
//   ST_WAIT | load outstanding; held fields drive outputs, timeout running
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_wb_reg_valid_i          instruction present in WB
//   mem_wb_reg_op_c_i           non-load result
//   mem_wb_reg_reg_waddr_i      destination register
//   mem_wb_reg_reg_we_i         instruction writes a register
//   mem_wb_reg_mtype_i          1 = load
//   mem_wb_reg_width_i          01 byte, 10 half, 11 word, 00 double (XLEN=64)
//   mem_wb_reg_unsigned_i       1 = zero-extend
//   mem_wb_reg_boff_i           byte offset of the load within the Dcache word
//   Dcache_data_i               load return data
//   fc_Dcache_data_valid_i      single-cycle pulse marking valid Dcache data
//   wb_op_c_o                   register write data
//   wb_reg_waddr_o              register write address
//   wb_reg_we_o                 register write enable
//   wb_stall_o                  hold mem_wb_reg and upstream stages
//   wb_load_err_o               one-cycle pulse on load timeout
//   wb_retire_cnt_o             completed-instruction count (wraps)

module wb_load_unit #(
    parameter int XLEN           = 32,
    parameter int REG_AW         = 5,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            mem_wb_reg_valid_i,
    input  logic [XLEN-1:0]                 mem_wb_reg_op_c_i,
    input  logic [REG_AW-1:0]               mem_wb_reg_reg_waddr_i,
    input  logic                            mem_wb_reg_reg_we_i,
    input  logic                            mem_wb_reg_mtype_i,
    input  logic [1:0]                      mem_wb_reg_width_i,
    input  logic                            mem_wb_reg_unsigned_i,
    input  logic [$clog2(XLEN/8)-1:0]       mem_wb_reg_boff_i,
    input  logic [XLEN-1:0]                 Dcache_data_i,
    input  logic                            fc_Dcache_data_valid_i,
    output logic [XLEN-1:0]                 wb_op_c_o,
    output logic [REG_AW-1:0]               wb_reg_waddr_o,
    output logic                            wb_reg_we_o,
    output logic                            wb_stall_o,
    output logic                            wb_load_err_o,
    output logic [CNT_W-1:0]                wb_retire_cnt_o
);

    localparam int BOFF_W = $clog2(XLEN/8);
    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TC_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic DWORD_OK = (XLEN == 64);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [TCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    retire_cnt_q;

    logic [REG_AW-1:0]   hold_waddr_q;
    logic                hold_we_q;
    logic [1:0]          hold_width_q;
    logic                hold_unsigned_q;
    logic [BOFF_W-1:0]   hold_boff_q;

    logic                capture;
    logic                retire;

    // Field select: in WAIT the upstream stage may already present other
    // values, so only the held copies are trusted.
    logic                in_wait;
    logic [REG_AW-1:0]   sel_waddr;
    logic                sel_we;
    logic [1:0]          sel_width;
    logic                sel_unsigned;
    logic [BOFF_W-1:0]   sel_boff;

    assign in_wait      = (state_q == ST_WAIT);
    assign sel_waddr    = in_wait ? hold_waddr_q    : mem_wb_reg_reg_waddr_i;
    assign sel_we       = in_wait ? hold_we_q       : mem_wb_reg_reg_we_i;
    assign sel_width    = in_wait ? hold_width_q    : mem_wb_reg_width_i;
    assign sel_unsigned = in_wait ? hold_unsigned_q : mem_wb_reg_unsigned_i;
    assign sel_boff     = in_wait ? hold_boff_q     : mem_wb_reg_boff_i;

    // Load formatting. Misaligned offsets are not trapped: whatever lands in
    // the low bits after the shift is used.
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] word_ext;
    logic [XLEN-1:0] load_data;
    logic            load_ok;

    assign shifted = Dcache_data_i >> {sel_boff, 3'b000};

    generate
        if (XLEN == 64) begin : g_word64
            assign word_ext = {{(XLEN-32){~sel_unsigned & shifted[31]}}, shifted[31:0]};
        end else begin : g_word32
            assign word_ext = shifted;
        end
    endgenerate

    always_comb begin
        load_data = '0;
        load_ok   = 1'b1;
        case (sel_width)
            2'b01:   load_data = {{(XLEN-8){~sel_unsigned & shifted[7]}}, shifted[7:0]};
            2'b10:   load_data = {{(XLEN-16){~sel_unsigned & shifted[15]}}, shifted[15:0]};
            2'b11:   load_data = word_ext;
            default: begin
                // Double is only meaningful on a 64-bit datapath.
                load_data = DWORD_OK ? shifted : '0;
                load_ok   = DWORD_OK;
            end
        endcase
    end

    logic waddr_nz;
    assign waddr_nz = (sel_waddr != '0);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        capture       = 1'b0;
        retire        = 1'b0;
        wb_stall_o    = 1'b0;
        wb_load_err_o = 1'b0;
        wb_reg_we_o   = 1'b0;
        wb_op_c_o     = mem_wb_reg_op_c_i;

        case (state_q)
            ST_IDLE: begin
                if (mem_wb_reg_valid_i) begin
                    if (!mem_wb_reg_mtype_i) begin
                        wb_reg_we_o = sel_we & waddr_nz;
                        retire      = 1'b1;
                    end else begin
                        wb_op_c_o = load_data;
                        if (fc_Dcache_data_valid_i) begin
                            wb_reg_we_o = sel_we & waddr_nz & load_ok;
                            retire      = 1'b1;
                        end else begin
                            wb_stall_o = 1'b1;
                            capture    = 1'b1;
                            wait_cnt_d = '0;
                            state_d    = ST_WAIT;
                        end
                    end
                end
            end

            ST_WAIT: begin
                wb_op_c_o = load_data;
                if (fc_Dcache_data_valid_i) begin
                    // Data beats the timeout when both land together.
                    wb_reg_we_o = sel_we & waddr_nz & load_ok;
                    retire      = 1'b1;
                    state_d     = ST_IDLE;
                end else if (wait_cnt_q == TC_LAST) begin
                    wb_load_err_o = 1'b1;
                    retire        = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wb_stall_o = 1'b1;
                    wait_cnt_d = wait_cnt_q + TCNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign wb_reg_waddr_o  = sel_waddr;
    assign wb_retire_cnt_o = retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_waddr_q    <= '0;
            hold_we_q       <= 1'b0;
            hold_width_q    <= 2'b00;
            hold_unsigned_q <= 1'b0;
            hold_boff_q     <= '0;
        end else if (capture) begin
            hold_waddr_q    <= mem_wb_reg_reg_waddr_i;
            hold_we_q       <= mem_wb_reg_reg_we_i;
            hold_width_q    <= mem_wb_reg_width_i;
            hold_unsigned_q <= mem_wb_reg_unsigned_i;
            hold_boff_q     <= mem_wb_reg_boff_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_load_unit.sv
module tb_wb_load_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel64;
    logic        valid;
    logic [63:0] op_c;
    logic [4:0]  waddr;
    logic        reg_we;
    logic        mtype;
    logic [1:0]  width;
    logic        uns;
    logic [2:0]  boff;
    logic [63:0] dcache;
    logic        dv;

    logic [31:0] o32_data;
    logic [4:0]  o32_waddr;
    logic        o32_we, o32_stall, o32_err;
    logic [31:0] o32_cnt;
    logic [63:0] o64_data;
    logic [4:0]  o64_waddr;
    logic        o64_we, o64_stall, o64_err;
    logic [3:0]  o64_cnt;

    int          n_total = 0;
    int          n_bad   = 0;
    int unsigned mcnt    = 0;

    always #5 clk = ~clk;

    wb_load_unit #(.XLEN(32), .REG_AW(5), .TIMEOUT_CYCLES(T), .CNT_W(32)) dut32 (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .mem_wb_reg_valid_i     (valid & ~sel64),
        .mem_wb_reg_op_c_i      (op_c[31:0]),
        .mem_wb_reg_reg_waddr_i (waddr),
        .mem_wb_reg_reg_we_i    (reg_we),
        .mem_wb_reg_mtype_i     (mtype),
        .mem_wb_reg_width_i     (width),
        .mem_wb_reg_unsigned_i  (uns),
        .mem_wb_reg_boff_i      (boff[1:0]),
        .Dcache_data_i          (dcache[31:0]),
        .fc_Dcache_data_valid_i (dv & ~sel64),
        .wb_op_c_o              (o32_data),
        .wb_reg_waddr_o         (o32_waddr),
        .wb_reg_we_o            (o32_we),
        .wb_stall_o             (o32_stall),
        .wb_load_err_o          (o32_err),
        .wb_retire_cnt_o        (o32_cnt)
    );

    wb_load_unit #(.XLEN(64), .REG_AW(5), .TIMEOUT_CYCLES(T), .CNT_W(4)) dut64 (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .mem_wb_reg_valid_i     (valid & sel64),
        .mem_wb_reg_op_c_i      (op_c),
        .mem_wb_reg_reg_waddr_i (waddr),
        .mem_wb_reg_reg_we_i    (reg_we),
        .mem_wb_reg_mtype_i     (mtype),
        .mem_wb_reg_width_i     (width),
        .mem_wb_reg_unsigned_i  (uns),
        .mem_wb_reg_boff_i      (boff),
        .Dcache_data_i          (dcache),
        .fc_Dcache_data_valid_i (dv & sel64),
        .wb_op_c_o              (o64_data),
        .wb_reg_waddr_o         (o64_waddr),
        .wb_reg_we_o            (o64_we),
        .wb_stall_o             (o64_stall),
        .wb_load_err_o          (o64_err),
        .wb_retire_cnt_o        (o64_cnt)
    );

    logic [63:0] obs_data;
    logic [4:0]  obs_waddr;
    logic        obs_we, obs_stall, obs_err;
    logic [31:0] obs_cnt;

    assign obs_data  = sel64 ? o64_data  : {32'b0, o32_data};
    assign obs_waddr = sel64 ? o64_waddr : o32_waddr;
    assign obs_we    = sel64 ? o64_we    : o32_we;
    assign obs_stall = sel64 ? o64_stall : o32_stall;
    assign obs_err   = sel64 ? o64_err   : o32_err;
    assign obs_cnt   = sel64 ? {28'b0, o64_cnt} : o32_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_model();
        return sel64 ? (mcnt % 16) : mcnt;
    endfunction

    // Reference load formatter: shift by whole bytes, take the low slice,
    // then sign/zero extend it by arithmetic on 64-bit values.
    function automatic void fmt(input bit is64, input logic [1:0] w, input bit u,
                                input int bo, input logic [63:0] d,
                                output logic [63:0] v, output bit ok);
        logic [63:0] sh;
        sh = (is64 ? d : (d & 64'hFFFF_FFFF)) >> (8 * bo);
        ok = 1'b1;
        case (w)
            2'd1: begin v = sh % 256;   if (!u && v >= 128)   v = v - 256; end
            2'd2: begin v = sh % 65536; if (!u && v >= 32768) v = v - 65536; end
            2'd3: begin
                if (!is64) v = sh;
                else begin
                    v = sh & 64'hFFFF_FFFF;
                    if (!u && v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
                end
            end
            default: begin
                if (is64) v = sh;
                else begin v = 64'd0; ok = 1'b0; end
            end
        endcase
        if (!is64) v = v & 64'hFFFF_FFFF;
    endfunction

    // One instruction in WB. k = cycles until the data pulse (0 = same
    // cycle); k > T means the data never comes and the load times out.
    task automatic run_txn(input bit is_load, input logic [63:0] opc, input logic [4:0] wa,
                           input bit we_f, input logic [1:0] w, input bit u,
                           input logic [2:0] bo, input logic [63:0] d, input int k);
        logic [63:0] exp_v;
        bit          ok;
        bit          done;
        int          bo_eff;
        bo_eff = sel64 ? int'(bo) : int'(bo % 4);
        fmt(sel64, w, u, bo_eff, d, exp_v, ok);
        if (!is_load) begin
            exp_v = sel64 ? opc : (opc & 64'hFFFF_FFFF);
            ok    = 1'b1;
        end

        @(posedge clk); #1;
        valid = 1'b1; mtype = is_load; op_c = opc; waddr = wa; reg_we = we_f;
        width = w; uns = u; boff = bo;
        dcache = (k == 0) ? d : {$urandom, $urandom};
        dv = (k == 0);
        done = 1'b0;
        for (int c = 0; c <= T && !done; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                op_c   = {$urandom, $urandom};
                waddr  = 5'($urandom);
                reg_we = 1'($urandom);
                mtype  = 1'($urandom);
                width  = 2'($urandom);
                uns    = 1'($urandom);
                boff   = 3'($urandom);
                dcache = (c == k) ? d : {$urandom, $urandom};
                dv     = (c == k);
            end
            @(negedge clk);
            if (!is_load || c == k) begin
                chk("we",    obs_we,    we_f && wa != 0 && ok);
                chk("data",  obs_data,  exp_v);
                chk("waddr", obs_waddr, wa);
                chk("stall", obs_stall, 0);
                chk("err",   obs_err,   0);
                done = 1'b1;
            end else if (c == T) begin
                chk("to_we",    obs_we,    0);
                chk("to_stall", obs_stall, 0);
                chk("to_err",   obs_err,   1);
                done = 1'b1;
            end else begin
                chk("w_we",    obs_we,    0);
                chk("w_stall", obs_stall, 1);
                chk("w_err",   obs_err,   0);
            end
        end
        mcnt++;
        @(posedge clk); #1;
        valid = 1'b0; dv = 1'b0;
        @(negedge clk);
        chk("cnt", obs_cnt, cnt_model());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel64 = 1'b0; valid = 1'b0; op_c = '0; waddr = '0; reg_we = 1'b0;
        mtype = 1'b0; width = 2'b00; uns = 1'b0; boff = '0; dcache = '0; dv = 1'b0;
        #12;
        chk("rst_we",     obs_we,    0);
        chk("rst_stall",  obs_stall, 0);
        chk("rst_err",    obs_err,   0);
        chk("rst_cnt",    obs_cnt,   0);
        chk("rst_cnt64",  {60'b0, o64_cnt}, 0);
        #11 rst_n = 1'b1;

        // Non-load pass-through, then to x0.
        run_txn(0, 64'h1234_5678, 5'd5, 1, 2'd0, 0, 3'd0, 64'd0, 0);
        run_txn(0, 64'h1234_5678, 5'd0, 1, 2'd0, 0, 3'd0, 64'd0, 0);
        // Byte / half formatting, same-cycle data.
        run_txn(1, 64'd0, 5'd3, 1, 2'd1, 0, 3'd1, 64'h80FF_7F80, 0);
        run_txn(1, 64'd0, 5'd3, 1, 2'd2, 0, 3'd2, 64'h80FF_7F80, 0);
        run_txn(1, 64'd0, 5'd3, 1, 2'd2, 1, 3'd2, 64'h80FF_7F80, 0);
        // Double width on a 32-bit datapath is never written.
        run_txn(1, 64'd0, 5'd9, 1, 2'd0, 0, 3'd0, 64'hCAFE_F00D, 0);
        // Late word load, 3 cycles.
        run_txn(1, 64'd0, 5'd12, 1, 2'd3, 0, 3'd0, 64'hDEAD_BEEF, 3);
        // Load to x0 arriving late.
        run_txn(1, 64'd0, 5'd0, 1, 2'd3, 0, 3'd0, 64'h1111_2222, 2);
        // Timeout, then stray data in IDLE.
        run_txn(1, 64'd0, 5'd7, 1, 2'd3, 0, 3'd0, 64'h5555_AAAA, T + 1);
        @(posedge clk); #1;
        dv = 1'b1; dcache = 64'h7777_7777;
        @(negedge clk);
        chk("stray_we",    obs_we,    0);
        chk("stray_stall", obs_stall, 0);
        @(posedge clk); #1; dv = 1'b0;
        @(negedge clk);
        chk("stray_cnt", obs_cnt, cnt_model());
        // Data in the final WAIT cycle.
        run_txn(1, 64'd0, 5'd8, 1, 2'd1, 1, 3'd3, 64'h9ABC_DEF0, T);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                    2'($urandom), 1'($urandom), 3'($urandom), {$urandom, $urandom},
                    int'($urandom_range(0, T + 1)));
        end

        // Reset in the middle of WAIT.
        @(posedge clk); #1;
        valid = 1'b1; mtype = 1'b1; width = 2'd3; waddr = 5'd7; reg_we = 1'b1; dv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0; valid = 1'b0;
        #1;
        mcnt = 0;
        chk("mrst_we",    obs_we,    0);
        chk("mrst_stall", obs_stall, 0);
        chk("mrst_err",   obs_err,   0);
        chk("mrst_cnt",   obs_cnt,   0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        dv = 1'b1; dcache = 64'h4444_4444;
        @(negedge clk);
        chk("mrst_late_we", obs_we, 0);
        @(posedge clk); #1; dv = 1'b0;
        @(negedge clk);
        chk("mrst_late_cnt", obs_cnt, 0);

        // 64-bit datapath: double load, then wrap a 4-bit retire counter.
        sel64 = 1'b1;
        mcnt  = 0;
        @(negedge clk);
        chk("c64_start", obs_cnt, 0);
        run_txn(1, 64'd0, 5'd10, 1, 2'd0, 0, 3'd0, 64'hFEDC_BA98_7654_3210, 0);
        run_txn(1, 64'd0, 5'd11, 1, 2'd1, 0, 3'd5, 64'h0080_0000_0000_0000, 2);
        run_txn(1, 64'd0, 5'd12, 1, 2'd3, 0, 3'd4, 64'h8000_0001_0000_0000, 0);
        for (int i = 0; i < 13; i++) begin
            run_txn(1'($urandom), {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                    2'($urandom), 1'($urandom), 3'($urandom), {$urandom, $urandom},
                    int'($urandom_range(0, T + 1)));
        end
        chk("wrap", obs_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
